esfa_host_master: RTL
=====================

// Module: esfa_host_master
// PURPOSE
//  Host-side initiator for the 8-cell ESFA memory array. Accepts write/metadata/query commands
//  on a valid/ready port, drives the array's write and selector inputs, samples the array's
//  result tree, and returns query results on a valid/ready response port.
// PARAMETERS
//  DW         8   data/index/metadata/selector width
//  QUERY_LAT  1   cycles from selector change to sampling result_bool/result_value (1..15)
//  IDLE_HOLD  2   consecutive cycles of result_bool==0 && result_value==0 needed to leave INIT
// PORTS
//  clk           in   1    clock, all logic on posedge
//  rst_n         in   1    asynchronous active-low reset
//  cmd_valid     in   1    command present
//  cmd_ready     out  1    master can accept command
//  cmd_op        in   2    0=WRITE, 1=WRITE_META, 2=QUERY, 3=reserved
//  cmd_index     in   DW   target index (write ops)
//  cmd_data      in   DW   value (WRITE), metadata (WRITE_META), selector (QUERY)
//  rsp_valid     out  1    response present
//  rsp_ready     in   1    response consumer ready
//  rsp_hit       out  1    sampled result_bool (0 for write acks)
//  rsp_value     out  DW   sampled result_value (0 for write acks)
//  arr_will_write out 1    array write strobe
//  arr_index     out  DW   array new_index
//  arr_value     out  DW   array new_value
//  arr_metadata  out  DW   array metadata
//  arr_is_meta   out  1    array isMetadata
//  arr_selector  out  DW   array selector
//  result_bool   in   1    array resultBool
//  result_value  in   DW   array resultValue
// BEHAVIOUR
//  - Reset: state=INIT; cmd_ready=0, rsp_valid=0, rsp_hit=0, rsp_value=0, arr_will_write=0,
//    arr_is_meta=0, arr_index/value/metadata/selector=0; counters=0.
//  - INIT: selector held 0; idle counter increments while result_bool==0 && result_value==0,
//    clears otherwise; on reaching IDLE_HOLD -> IDLE (array's internal init has completed).
//  - IDLE: cmd_ready=1. Handshake on cmd_valid&&cmd_ready; one command in flight at a time.
//    WRITE/WRITE_META -> WRITE; QUERY -> QWAIT; op 3 is consumed and dropped (stay IDLE).
//  - WRITE (1 cycle): arr_will_write=1, arr_index=cmd_index, arr_value or arr_metadata=cmd_data,
//    arr_is_meta=(op==WRITE_META); next cycle strobe deasserts; -> IDLE (or RESP, see macro).
//    arr_index/value/metadata/is_meta hold last written values when idle.
//  - QWAIT: arr_selector=cmd_data registered at handshake; latency counter counts QUERY_LAT
//    cycles, then samples result_bool/result_value into rsp_hit/rsp_value -> RESP.
//  - RESP: rsp_valid=1, payload stable until rsp_valid&&rsp_ready; then -> IDLE, rsp_valid=0.
//    Back-to-back: cmd_ready is 0 in WRITE/QWAIT/RESP; min query turnaround QUERY_LAT+2 cycles.
//  - arr_will_write never asserted outside WRITE; never asserted during INIT.
//  - rst_n low mid-operation: all outputs return to reset values immediately (async); pending
//    command/response discarded; INIT re-entered.
//  - Latency counter width 4 bits; QUERY_LAT=0 is illegal (elaboration error).
// CONFIGURATION
//  ESFA_WRITE_ACK_EN defined: WRITE/WRITE_META go to RESP after the strobe cycle, returning
//    rsp_hit=0, rsp_value=0 as an acknowledgement. Undefined: writes return to IDLE, no response.
// STRUCTURE
//  - esfa_pkg: DW default, op codes (OP_WRITE/OP_WRITE_META/OP_QUERY), state enum
//    (INIT/IDLE/WRITE/QWAIT/RESP).
//  - Single module; no sub-module needed (latency and idle counters inline).
// TESTING
//  1 Reset release, array outputs 0 -> cmd_ready rises exactly IDLE_HOLD+1 cycles after rst_n.
//  2 WRITE idx=3 data=0x5A -> one-cycle arr_will_write, arr_index=3, arr_value=0x5A, is_meta=0.
//  3 WRITE_META idx=3 data=0x11 then QUERY sel=0x11 with model returning bool=1,val=0x5A ->
//    rsp_hit=1, rsp_value=0x5A, rsp_valid asserted QUERY_LAT+1 cycles after handshake.
//  4 rsp_ready held 0 for 5 cycles -> rsp payload stable, cmd_ready=0, no new array activity.
//  5 rst_n asserted during QWAIT -> rsp_valid never rises, outputs reset, INIT re-entered.
//  6 ESFA_WRITE_ACK_EN on/off: WRITE -> ack rsp(0,0) vs. no rsp_valid; op=3 -> dropped, no strobe.

Source files
------------

// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA host-side initiator: default width, command op codes, FSM states.
package esfa_pkg;

    localparam int DW_DEFAULT = 8;

    localparam logic [1:0] OP_WRITE      = 2'd0;
    localparam logic [1:0] OP_WRITE_META = 2'd1;
    localparam logic [1:0] OP_QUERY      = 2'd2;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        WRITE = 3'd2,
        QWAIT = 3'd3,
        RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/esfa_host_master.sv
// Host initiator for the 8-cell ESFA array: command port in, array drive/sample, response port out.
// Build option ESFA_WRITE_ACK_EN: writes return a (hit=0, value=0) acknowledgement response.
//
// state | meaning
// INIT  | waiting for the array's result tree to read all-zero for IDLE_HOLD cycles
// IDLE  | cmd_ready=1, accepting one command
// WRITE | single-cycle array write strobe
// QWAIT | selector applied, latency down-counter running
// RESP  | response held until consumed
module esfa_host_master
    import esfa_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int QUERY_LAT = 1,
    parameter int IDLE_HOLD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_index,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_hit,
    output logic [DW-1:0] rsp_value,
    output logic          arr_will_write,
    output logic [DW-1:0] arr_index,
    output logic [DW-1:0] arr_value,
    output logic [DW-1:0] arr_metadata,
    output logic          arr_is_meta,
    output logic [DW-1:0] arr_selector,
    input  logic          result_bool,
    input  logic [DW-1:0] result_value
);

    generate
        if (QUERY_LAT < 1 || QUERY_LAT > 15) begin : g_bad_query_lat
            $error("esfa_host_master: QUERY_LAT must be in 1..15");
        end
        if (IDLE_HOLD < 0 || IDLE_HOLD > 15) begin : g_bad_idle_hold
            $error("esfa_host_master: IDLE_HOLD must be in 0..15");
        end
    endgenerate

    localparam logic [3:0] LAT_LOAD  = 4'(QUERY_LAT);
    localparam logic [3:0] IDLE_TERM = 4'(IDLE_HOLD);

    state_e        state_q, state_d;
    logic [3:0]    idle_cnt_q, idle_cnt_d;
    logic [3:0]    lat_cnt_q, lat_cnt_d;
    logic [DW-1:0] arr_index_q, arr_index_d;
    logic [DW-1:0] arr_value_q, arr_value_d;
    logic [DW-1:0] arr_metadata_q, arr_metadata_d;
    logic          arr_is_meta_q, arr_is_meta_d;
    logic [DW-1:0] arr_selector_q, arr_selector_d;
    logic          rsp_hit_q, rsp_hit_d;
    logic [DW-1:0] rsp_value_q, rsp_value_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= INIT;
            idle_cnt_q     <= '0;
            lat_cnt_q      <= '0;
            arr_index_q    <= '0;
            arr_value_q    <= '0;
            arr_metadata_q <= '0;
            arr_is_meta_q  <= 1'b0;
            arr_selector_q <= '0;
            rsp_hit_q      <= 1'b0;
            rsp_value_q    <= '0;
        end else begin
            state_q        <= state_d;
            idle_cnt_q     <= idle_cnt_d;
            lat_cnt_q      <= lat_cnt_d;
            arr_index_q    <= arr_index_d;
            arr_value_q    <= arr_value_d;
            arr_metadata_q <= arr_metadata_d;
            arr_is_meta_q  <= arr_is_meta_d;
            arr_selector_q <= arr_selector_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_value_q    <= rsp_value_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idle_cnt_d     = idle_cnt_q;
        lat_cnt_d      = lat_cnt_q;
        arr_index_d    = arr_index_q;
        arr_value_d    = arr_value_q;
        arr_metadata_d = arr_metadata_q;
        arr_is_meta_d  = arr_is_meta_q;
        arr_selector_d = arr_selector_q;
        rsp_hit_d      = rsp_hit_q;
        rsp_value_d    = rsp_value_q;

        case (state_q)
            INIT: begin
                arr_selector_d = '0;
                // Any non-zero result means the array is still initialising; restart the count.
                if (!result_bool && (result_value == '0)) begin
                    if (idle_cnt_q >= IDLE_TERM) begin
                        idle_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 4'd1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            arr_index_d   = cmd_index;
                            arr_value_d   = cmd_data;
                            arr_is_meta_d = 1'b0;
                            state_d       = WRITE;
                        end
                        OP_WRITE_META: begin
                            arr_index_d    = cmd_index;
                            arr_metadata_d = cmd_data;
                            arr_is_meta_d  = 1'b1;
                            state_d        = WRITE;
                        end
                        OP_QUERY: begin
                            arr_selector_d = cmd_data;
                            lat_cnt_d      = LAT_LOAD;
                            state_d        = QWAIT;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WRITE: begin
`ifdef ESFA_WRITE_ACK_EN
                rsp_hit_d   = 1'b0;
                rsp_value_d = '0;
                state_d     = RESP;
`else
                state_d     = IDLE;
`endif
            end
            QWAIT: begin
                if (lat_cnt_q != 4'd0) begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end else begin
                    rsp_hit_d   = result_bool;
                    rsp_value_d = result_value;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Handshake and strobe outputs decode directly from the state register.
    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = (state_q == RESP);
    assign arr_will_write = (state_q == WRITE);
    assign rsp_hit        = rsp_hit_q;
    assign rsp_value      = rsp_value_q;
    assign arr_index      = arr_index_q;
    assign arr_value      = arr_value_q;
    assign arr_metadata   = arr_metadata_q;
    assign arr_is_meta    = arr_is_meta_q;
    assign arr_selector   = arr_selector_q;

endmodule
